osd_du_arbiter: RTL and testbench
=================================

# osd_du_arbiter

Round-robin arbiter sharing one CPU core debug-unit (DU) bus between `NUM_PORTS` debug requesters, e.g. the core debug module and a breakpoint/trace module. Each requester issues single register accesses (read/write), and the arbiter sequences them one at a time onto the DU strobe/ack bus. It aborts any access the core never acknowledges, merges the requesters' stall requests into the core stall input, and reports stall entry as a one-cycle event pulse. It sits between the debug modules and the core DU pins.

## Interface
- `NUM_PORTS`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 16: DU register address width.
- `DATA_WIDTH`, 32: DU data width.
- `TIMEOUT`, 255: cycles to wait for `du_ack_o` before aborting; 0 disables the timeout.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_stb`  in  NUM_PORTS  per-port access request; held until that port's ack or err.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_adr`  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  per-port write data, same packing.
- `req_ack`  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- `req_err`  out  NUM_PORTS  one-cycle timeout-abort pulse to the granted port.
- `req_rdata`  out  DATA_WIDTH  read data, shared by all ports; valid in the cycle of `req_ack`.
- `req_stall`  in  NUM_PORTS  per-port core-stall request.
- `cpu_stalled`  out  1  registered copy of `du_stall_o`.
- `stall_event`  out  1  one-cycle pulse on a rising edge of `du_stall_o`.
- `busy`  out  1  high while the arbiter is not in IDLE.
- `du_stall_i`  out  1  core stall.
- `du_stall_o`  in  1  core reports that it is halted.
- `du_stb_i`  out  1  DU access strobe.
- `du_ack_o`  in  1  DU access complete.
- `du_adr_i`  out  ADDR_WIDTH  DU address.
- `du_we_i`  out  1  DU write enable.
- `du_dat_i`  out  DATA_WIDTH  DU write data.
- `du_dat_o`  in  DATA_WIDTH  DU read data.

## Operation
- **Reset values:** every output is 0. The round-robin pointer is 0, so port 0 has highest priority on the first arbitration. State is IDLE.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req_stb` is high, grant the first requesting port at or after the pointer (wrapping at NUM_PORTS).
  - Latch the grant index and that port's `req_adr`, `req_we` and `req_wdata` into registers.
  - Clear the timeout counter and go to ACCESS.
- **ACCESS:**
  - Drive `du_stb_i`=1; `du_adr_i`, `du_we_i` and `du_dat_i` come from the latched registers and stay stable for the whole access.
  - On `du_ack_o`=1: capture `du_dat_o` into `req_rdata` (for writes as well; the value is don't-care), set the ack flag, go to RESP.
  - Otherwise, if TIMEOUT≠0 and the counter equals TIMEOUT-1: set the err flag and go to RESP. If not, increment the counter.
  - If `du_ack_o` arrives in the same cycle the timeout would fire, ack wins.
- **RESP:**
  - `du_stb_i`=0.
  - Assert `req_ack[g]` or `req_err[g]` for exactly this one cycle, where g is the granted port.
  - Set the pointer to (g+1) mod NUM_PORTS and go to IDLE.
- **Requester contract:** a requester must drop `req_stb` in the cycle after it sees ack/err. If it drops `req_stb` early during ACCESS, the access still completes and still pulses ack/err.
- **Stall path:**
  - `du_stall_i` is the OR of `req_stall`, registered (one cycle of latency), independent of the FSM.
  - `cpu_stalled` is `du_stall_o` registered. `stall_event` = `du_stall_o` & ~`cpu_stalled`.
- **Reset mid-access:** `du_stb_i` drops immediately (asynchronously). No ack or err is issued.
- **Counter width:** $clog2(TIMEOUT+1), minimum 1.

## Timing
- Request seen in IDLE at cycle 0 → `du_stb_i` high from cycle 1.
- `du_ack_o` sampled high in cycle k → `req_ack` and `req_rdata` valid in cycle k+1, `du_stb_i` low in k+1. The earliest next strobe is cycle k+3.
- No ack: `du_stb_i` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT), then `req_err` pulses in cycle TIMEOUT+1.
- `busy` is high in ACCESS and RESP.
- Exactly one of `req_ack`/`req_err` is high, on one bit only, and only in RESP.
- `req_stall` → `du_stall_i`: 1 cycle. `du_stall_o` rising → `stall_event`: same cycle, combinational from the registered history.

## Test plan
- **Single read:** port 0 reads adr 0x8010; DU acks 3 cycles after the strobe with 0xDEADBEEF → `du_adr_i`=0x8010 and `du_we_i`=0 throughout, `req_ack`=2'b01 for one cycle, `req_rdata`=0xDEADBEEF.
- **Round-robin:** ports 0 and 1 request continuously, DU acks immediately → grants alternate 0,1,0,1. The first grant goes to port 0 after reset.
- **Timeout:** TIMEOUT=4, port 1 writes 0x12345678 and the DU never acks → `du_stb_i` high for 4 cycles, then `req_err`=2'b10 for one cycle, no `req_ack`, FSM back in IDLE.
- **Ack/timeout collision:** TIMEOUT=4, ack arrives in the 4th strobe cycle → `req_ack` pulses, `req_err` stays 0.
- **Stall:** raise `req_stall[1]` → `du_stall_i`=1 one cycle later; core raises `du_stall_o` → `stall_event` is a single one-cycle pulse and `cpu_stalled` follows one cycle later; drop `req_stall` → `du_stall_i` falls one cycle later.
- **Reset mid-access:** assert `rst` during ACCESS → `du_stb_i`=0 at once, no ack/err. After release, a pending port 1 request is granted (pointer back at 0, and port 0 is idle).

Source files
------------

// File: rtl/osd_du_arbiter.sv
// Round-robin arbiter sharing one core debug-unit bus between NUM_PORTS requesters.
// It sequences single accesses, aborts unacknowledged ones and merges stall requests.
module osd_du_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_stb,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_adr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic [NUM_PORTS-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  input  logic [NUM_PORTS-1:0]            req_stall,
  output logic                            cpu_stalled,
  output logic                            stall_event,
  output logic                            busy,
  output logic                            du_stall_i,
  input  logic                            du_stall_o,
  output logic                            du_stb_i,
  input  logic                            du_ack_o,
  output logic [ADDR_WIDTH-1:0]           du_adr_i,
  output logic                            du_we_i,
  output logic [DATA_WIDTH-1:0]           du_dat_i,
  input  logic [DATA_WIDTH-1:0]           du_dat_o
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);
  localparam logic [GW:0]   NP        = (GW + 1)'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] adr_arr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_arr;
  assign adr_arr   = req_adr;
  assign wdata_arr = req_wdata;

  state_e                state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d, gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stb_q, stb_d;
  logic [NUM_PORTS-1:0]  ack_q, ack_d, err_q, err_d;
  logic                  stall_q, stall_d, cpu_stalled_q, cpu_stalled_d;

  // Rotate requests so bit 0 is the pointer's port; first set bit wins.
  logic [2*NUM_PORTS-1:0] req_rot;
  logic                   found;
  logic [GW:0]            pick_sum;
  logic [GW-1:0]          pick;

  always_comb begin
    req_rot  = {req_stb, req_stb} >> ptr_q;
    found    = 1'b0;
    pick     = ptr_q;
    pick_sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        pick_sum = {1'b0, ptr_q} + (GW + 1)'(i);
        if (pick_sum >= NP) pick_sum = pick_sum - NP;
        pick = pick_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          adr_d   = adr_arr[pick];
          we_d    = req_we[pick];
          wdata_d = wdata_arr[pick];
          cnt_d   = '0;
          stb_d   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ack has priority over a timeout firing in the same cycle.
        if (du_ack_o) begin
          rdata_d       = du_dat_o;
          ack_d[gnt_q]  = 1'b1;
          stb_d         = 1'b0;
          state_d       = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          err_d[gnt_q]  = 1'b1;
          stb_d         = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == LAST_PORT) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign stall_d       = |req_stall;
  assign cpu_stalled_d = du_stall_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      adr_q         <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      stb_q         <= 1'b0;
      ack_q         <= '0;
      err_q         <= '0;
      stall_q       <= 1'b0;
      cpu_stalled_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      adr_q         <= adr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      stb_q         <= stb_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      stall_q       <= stall_d;
      cpu_stalled_q <= cpu_stalled_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_err     = err_q;
  assign req_rdata   = rdata_q;
  assign busy        = (state_q != IDLE);
  assign du_stb_i    = stb_q;
  assign du_adr_i    = adr_q;
  assign du_we_i     = we_q;
  assign du_dat_i    = wdata_q;
  assign du_stall_i  = stall_q;
  assign cpu_stalled = cpu_stalled_q;
  assign stall_event = du_stall_o & ~cpu_stalled_q;

endmodule

// File: tb/tb_osd_du_arbiter.sv
// Directed bench for osd_du_arbiter: read, round-robin, timeout, collision, stall, reset.
module tb_osd_du_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_stb, req_we, req_stall;
  logic [1:0][15:0] req_adr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_ack, req_err;
  logic [31:0]      req_rdata;
  logic             cpu_stalled, stall_event, busy, du_stall_i, du_stall_o;
  logic             du_stb_i, du_ack_o, du_we_i;
  logic [15:0]      du_adr_i;
  logic [31:0]      du_dat_i, du_dat_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  osd_du_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_we(req_we), .req_adr(req_adr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .req_stall(req_stall), .cpu_stalled(cpu_stalled), .stall_event(stall_event),
    .busy(busy), .du_stall_i(du_stall_i), .du_stall_o(du_stall_o),
    .du_stb_i(du_stb_i), .du_ack_o(du_ack_o), .du_adr_i(du_adr_i),
    .du_we_i(du_we_i), .du_dat_i(du_dat_i), .du_dat_o(du_dat_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_stb = '0; req_we = '0; req_stall = '0; req_adr = '0; req_wdata = '0;
    du_stall_o = 1'b0; du_ack_o = 1'b0; du_dat_o = '0;
    tick(); tick();
    chk("rst_stb",   32'(du_stb_i), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_ack",   32'(req_ack), 32'h0);
    chk("rst_err",   32'(req_err), 32'h0);
    chk("rst_rdata", req_rdata, 32'h0);
    chk("rst_adr",   32'(du_adr_i), 32'h0);
    chk("rst_stall", 32'(du_stall_i), 32'h0);
    rst = 1'b0;

    // Single read from port 0, ack in the 3rd strobe cycle.
    req_stb = 2'b01; req_we = 2'b00; req_adr[0] = 16'h8010;
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("rd_stb", 32'(du_stb_i), 32'h1);
      chk("rd_adr", 32'(du_adr_i), 32'h8010);
      chk("rd_we",  32'(du_we_i), 32'h0);
      chk("rd_ack_early", 32'(req_ack), 32'h0);
      if (c == 3) begin du_ack_o = 1'b1; du_dat_o = 32'hDEADBEEF; end
      tick();
    end
    chk("rd_ack",   32'(req_ack), 32'h1);
    chk("rd_rdata", req_rdata, 32'hDEADBEEF);
    chk("rd_stb_low", 32'(du_stb_i), 32'h0);
    chk("rd_busy_resp", 32'(busy), 32'h1);
    req_stb = 2'b00; du_ack_o = 1'b0;
    tick();
    chk("rd_ack_one", 32'(req_ack), 32'h0);
    chk("rd_idle", 32'(busy), 32'h0);

    // Round-robin from a fresh pointer, DU acks immediately.
    do_reset();
    req_adr[0] = 16'h0A00; req_adr[1] = 16'h0B11;
    req_stb = 2'b11;
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("rr_stb", 32'(du_stb_i), 32'h1);
      chk("rr_adr", 32'(du_adr_i), (g % 2 == 0) ? 32'h0A00 : 32'h0B11);
      du_ack_o = 1'b1; du_dat_o = 32'h100 + 32'(g);
      tick();
      du_ack_o = 1'b0;
      chk("rr_ack",   32'(req_ack), (g % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rdata", req_rdata, 32'h100 + 32'(g));
      if (g == 3) req_stb = 2'b00;
      tick();
      if (g != 3) tick();
    end
    chk("rr_idle", 32'(busy), 32'h0);

    // Timeout: port 1 write, never acknowledged.
    req_stb = 2'b10; req_we = 2'b10; req_adr[1] = 16'h0004; req_wdata[1] = 32'h12345678;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("to_stb", 32'(du_stb_i), 32'h1);
      chk("to_we",  32'(du_we_i), 32'h1);
      chk("to_dat", du_dat_i, 32'h12345678);
      chk("to_err_early", 32'(req_err), 32'h0);
      tick();
    end
    chk("to_stb_low", 32'(du_stb_i), 32'h0);
    chk("to_err", 32'(req_err), 32'h2);
    chk("to_noack", 32'(req_ack), 32'h0);
    req_stb = 2'b00; req_we = 2'b00;
    tick();
    chk("to_err_one", 32'(req_err), 32'h0);
    chk("to_idle", 32'(busy), 32'h0);

    // Ack in the 4th strobe cycle collides with the timeout; ack wins.
    req_stb = 2'b01;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("col_stb", 32'(du_stb_i), 32'h1);
      if (c == 4) begin du_ack_o = 1'b1; du_dat_o = 32'hCAFE0004; end
      tick();
    end
    du_ack_o = 1'b0;
    chk("col_ack", 32'(req_ack), 32'h1);
    chk("col_err", 32'(req_err), 32'h0);
    chk("col_rdata", req_rdata, 32'hCAFE0004);
    req_stb = 2'b00;
    tick();
    chk("col_idle", 32'(busy), 32'h0);

    // Stall path.
    req_stall = 2'b10;
    #1;
    chk("st_lat", 32'(du_stall_i), 32'h0);
    tick();
    chk("st_on", 32'(du_stall_i), 32'h1);
    du_stall_o = 1'b1;
    #1;
    chk("st_evt", 32'(stall_event), 32'h1);
    chk("st_cpu0", 32'(cpu_stalled), 32'h0);
    tick();
    chk("st_cpu1", 32'(cpu_stalled), 32'h1);
    chk("st_evt_one", 32'(stall_event), 32'h0);
    req_stall = 2'b00;
    tick();
    chk("st_hold", 32'(stall_event), 32'h0);
    chk("st_off", 32'(du_stall_i), 32'h0);
    du_stall_o = 1'b0;
    tick();

    // Reset during an access (pointer is at port 1 here).
    req_stb = 2'b10; req_adr[1] = 16'h0C22;
    tick();
    chk("rm_stb", 32'(du_stb_i), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_stb_async", 32'(du_stb_i), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    tick();
    chk("rm_ack", 32'(req_ack), 32'h0);
    chk("rm_err", 32'(req_err), 32'h0);
    rst = 1'b0;
    tick();
    chk("rm_regrant", 32'(du_stb_i), 32'h1);
    chk("rm_adr", 32'(du_adr_i), 32'h0C22);
    du_ack_o = 1'b1;
    tick();
    du_ack_o = 1'b0;
    chk("rm_ack2", 32'(req_ack), 32'h2);
    req_stb = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
